keyfile_loader: RTL

- Sequences fetch of the 64-bit keyfile from the key-store read port (4 x 16-bit words, req/ack handshake).
- Commits the assembled key atomically to key_data_out / key_valid, which feed the keyfile read-only peripheral.
- Exposes an openMSP430 peripheral with a CTRL register (reload/zeroize/lock) and a STATUS register.
- Autoloads after reset.

---
 rtl/keyfile_loader_if.sv | 27 ++
 rtl/keyfile_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/keyfile_loader_if.sv
// Peripheral-bus and key-store read-port signals of the keyfile loader.
// The loader takes the slave side; the CPU/key-store environment takes the master side.
interface keyfile_loader_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        ks_req;
  logic [1:0]  ks_addr;
  logic        ks_ack;
  logic [15:0] ks_data;

  modport master (
    output per_addr, per_din, per_en, per_we,
    input  per_dout,
    input  ks_req, ks_addr,
    output ks_ack, ks_data
  );

  modport slave (
    input  per_addr, per_din, per_en, per_we,
    output per_dout,
    output ks_req, ks_addr,
    input  ks_ack, ks_data
  );
endinterface

// File: rtl/keyfile_loader.sv
// Fetches the 64-bit keyfile as four 16-bit key-store words and commits it atomically,
// with a CTRL (reload/zeroize/lock) and STATUS register on the peripheral bus.
module keyfile_loader #(
  parameter logic [14:0] BASE_ADDR = 15'h01A8,
  parameter int          DEC_WD    = 2,
  parameter int          TIMEOUT   = 255,
  parameter bit          AUTOLOAD  = 1'b1
) (
  input  logic                   mclk,
  input  logic                   puc_rst_n,
  keyfile_loader_if.slave        bus,
  output logic [63:0]            key_data_out,
  output logic                   key_valid,
  output logic                   busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DONE, S_ERR} state_t;

  localparam int                CNT_WD   = 16;
  localparam logic [DEC_WD-1:0] OFF_CTRL = '0;
  localparam logic [DEC_WD-1:0] OFF_STAT = DEC_WD'(2);

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [63:0]         shadow_q, shadow_d;
  logic [63:0]         key_q, key_d;
  logic                kvalid_q, kvalid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                reload_q, reload_d;
  logic                zero_q, zero_d;
  logic                locked_q, locked_d;
  logic                auto_q;

  logic                reg_sel, reg_wr, reg_rd, ctrl_wr, start;
  logic [DEC_WD-1:0]   reg_off;
  logic                unused_din;

  // Register decode
  assign reg_sel = bus.per_en && (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off = {bus.per_addr[DEC_WD-2:0], 1'b0};
  assign reg_wr  = reg_sel && (|bus.per_we);
  assign reg_rd  = reg_sel && !(|bus.per_we);
  assign ctrl_wr = reg_wr && (reg_off == OFF_CTRL);
  assign unused_din = ^bus.per_din[15:3];

  // CTRL strobes land one cycle after the write; only LOCK is sticky
  assign reload_d = ctrl_wr && bus.per_din[0];
  assign zero_d   = ctrl_wr && bus.per_din[1];
  assign locked_d = locked_q || (ctrl_wr && bus.per_din[2]);

  assign start = (state_q == S_IDLE) && !zero_q && (auto_q || (reload_q && !locked_q));

  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      kvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      reload_q <= 1'b0;
      zero_q   <= 1'b0;
      locked_q <= 1'b0;
      auto_q   <= AUTOLOAD;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      kvalid_q <= kvalid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      reload_q <= reload_d;
      zero_q   <= zero_d;
      locked_q <= locked_d;
      auto_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    kvalid_d = kvalid_q;
    busy_d   = busy_q;
    err_d    = err_q;
    if (zero_q) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      shadow_d = '0;
      key_d    = '0;
      kvalid_d = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_REQ;
            idx_d    = '0;
            cnt_d    = '0;
            key_d    = '0;
            kvalid_d = 1'b0;
            err_d    = 1'b0;
            busy_d   = 1'b1;
          end
        end
        S_REQ: begin
          if (bus.ks_ack) begin
            // word 0 lands in the top 16 bits, word 3 in the bottom
            shadow_d[{~idx_q, 4'b0000} +: 16] = bus.ks_data;
            cnt_d = '0;
            if (idx_q == 2'd3) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_GAP;
            end
          end else if (cnt_q == CNT_WD'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            state_d = S_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: state_d = S_REQ;
        S_DONE: begin
          key_d    = shadow_q;
          kvalid_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
        S_ERR: begin
          err_d    = 1'b1;
          shadow_d = '0;
          kvalid_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // a pending zeroize drops the request in the same cycle it takes effect
    bus.ks_req   = (state_q == S_REQ) && !zero_q;
    bus.ks_addr  = idx_q;
    bus.per_dout = '0;
    if (reg_rd && (reg_off == OFF_CTRL)) begin
      bus.per_dout = {13'b0, locked_q, 2'b0};
    end else if (reg_rd && (reg_off == OFF_STAT)) begin
      bus.per_dout = {10'b0, idx_q, locked_q, err_q, kvalid_q, busy_q};
    end
  end

  assign key_data_out = key_q;
  assign key_valid    = kvalid_q;
  assign busy         = busy_q;

endmodule
